div16_16_seq: RTL and testbench



---
 rtl/div16_16_seq_pkg.sv | 26 ++
 rtl/div16_16_seq_udiv_step.sv | 21 ++
 rtl/div16_16_seq.sv | 143 ++++++++++++++
 tb/tb_div16_16_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/div16_16_seq_pkg.sv
// Shared constants, state encoding and helpers for the Q2.14 sequential divider.
// The optional DIV16_ROUND_EN macro (used in div16_16_seq.sv) selects round-half-away-from-zero.
package div16_16_seq_pkg;

    localparam int DIV_FRAC_BITS = 14;
    localparam int DIV_WIDTH     = 16;

    localparam logic [DIV_WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DIV_WIDTH-1:0] Q_MIN = 16'h8000;
    localparam logic [DIV_WIDTH-1:0] Q_ONE = 16'h4000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One extra bit so that |-32768| = 32768 is representable.
    function automatic logic [DIV_WIDTH:0] abs_mag(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH:0] ext;
        ext = {v[DIV_WIDTH-1], v};
        return v[DIV_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/div16_16_seq_udiv_step.sv
// Single combinational restoring-division step: shift one dividend bit into the
// partial remainder and subtract the divisor when it fits.
module udiv_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] rem_in,
    input  logic         dvd_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] trial;

    always_comb begin
        trial   = {rem_in, dvd_bit};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
    end

endmodule

// File: rtl/div16_16_seq.sv
// Sequential signed Q2.14 divider, q = (a << 14) / b, one quotient bit per cycle.
// Define DIV16_ROUND_EN for round-half-away-from-zero instead of truncation.
module div16_16_seq
    import div16_16_seq_pkg::*;
#(
    parameter int FRAC_BITS = DIV_FRAC_BITS,
    parameter int WIDTH     = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             overflow,
    output logic             div_zero
);

    localparam int MAG_W = WIDTH + 1;
    localparam int DVD_W = FRAC_BITS + WIDTH;
    localparam int CNT_W = $clog2(DVD_W);

    state_t             state_reg, state_next;
    logic [MAG_W-1:0]   bmag_reg;
    logic [MAG_W-1:0]   rem_reg;
    logic [DVD_W-1:0]   dvd_reg;     // dividend shifts out of the top, quotient bits shift in below
    logic [CNT_W-1:0]   cnt_reg;
    logic               sign_reg;
    logic               a_neg_reg;
    logic               zero_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               overflow_reg;
    logic               div_zero_reg;
    logic               out_valid_reg;

    logic [MAG_W-1:0]           rem_step;
    logic                       q_bit;
    logic [MAG_W+FRAC_BITS-1:0] a_shift;
    logic [DVD_W:0]             mag;
    logic [DVD_W:0]             limit;
    logic [DVD_W:0]             q_mag;
    logic                       sat;
    logic [WIDTH-1:0]           q_fix;
    logic                       overflow_fix;

    udiv_step #(.W(MAG_W)) u_step (
        .rem_in  (rem_reg),
        .dvd_bit (dvd_reg[DVD_W-1]),
        .divisor (bmag_reg),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: if (cnt_reg == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_valid_reg && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign application and saturation of the final magnitude.
    always_comb begin
        a_shift = {abs_mag(a), {FRAC_BITS{1'b0}}};
        mag     = {1'b0, dvd_reg};
`ifdef DIV16_ROUND_EN
        if ({rem_reg, 1'b0} >= {1'b0, bmag_reg}) mag = mag + 1'b1;
`endif
        limit        = sign_reg ? (DVD_W+1)'(1 << (WIDTH-1)) : (DVD_W+1)'((1 << (WIDTH-1)) - 1);
        sat          = (mag > limit);
        q_mag        = sat ? limit : mag;
        q_fix        = sign_reg ? (~q_mag[WIDTH-1:0] + 1'b1) : q_mag[WIDTH-1:0];
        overflow_fix = sat;
        if (zero_reg) begin
            q_fix        = a_neg_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            overflow_fix = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bmag_reg      <= '0;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            cnt_reg       <= '0;
            sign_reg      <= 1'b0;
            a_neg_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            q_reg         <= '0;
            overflow_reg  <= 1'b0;
            div_zero_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    bmag_reg  <= abs_mag(b);
                    rem_reg   <= '0;
                    dvd_reg   <= a_shift[DVD_W-1:0];
                    cnt_reg   <= CNT_W'(DVD_W - 1);
                    sign_reg  <= a[WIDTH-1] ^ b[WIDTH-1];
                    a_neg_reg <= a[WIDTH-1];
                    zero_reg  <= (b == '0);
                end
                CALC: begin
                    rem_reg <= rem_step;
                    dvd_reg <= {dvd_reg[DVD_W-2:0], q_bit};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                FIX: begin
                    q_reg        <= q_fix;
                    overflow_reg <= overflow_fix;
                    div_zero_reg <= zero_reg;
                end
                DONE: begin
                    if (!out_valid_reg)  out_valid_reg <= 1'b1;
                    else if (out_ready)  out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign q         = q_reg;
    assign overflow  = overflow_reg;
    assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div16_16_seq.sv
// Directed testbench for div16_16_seq: latency, sign/saturation, divide-by-zero,
// output back-pressure and asynchronous reset mid-operation.
module tb_div16_16_seq;
    import div16_16_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        overflow;
    logic        div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    div16_16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present operands and return just after the accepting edge.
    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; counts edges until out_valid.
    task automatic wait_result(input string tag, input logic [15:0] eq,
                               input logic eov, input logic edz);
        int n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, n, 32);
        check({tag, ".q"}, q, eq);
        check({tag, ".overflow"}, overflow, eov);
        check({tag, ".div_zero"}, div_zero, edz);
        $display("op %s a=0x%04h b=0x%04h -> q=0x%04h ovf=%0b dz=%0b lat=%0d",
                 tag, a, b, q, overflow, div_zero, n);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] eq, input logic eov, input logic edz);
        start_op(tag, av, bv);
        wait_result(tag, eq, eov, edz);
        @(posedge clk);
        #1;
        check({tag, ".out_valid_drop"}, out_valid, 0);
        check({tag, ".in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.q", q, 0);
        check("reset.overflow", overflow, 0);
        check("reset.div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("half_by_one", 16'h2000, Q_ONE, 16'h2000, 1'b0, 1'b0);
        run_op("neg_exact_min", 16'hC000, 16'h2000, Q_MIN, 1'b0, 1'b0);
        run_op("pos_saturate", Q_ONE, 16'h2000, Q_MAX, 1'b1, 1'b0);
        run_op("divzero_pos", Q_ONE, 16'h0000, Q_MAX, 1'b0, 1'b1);
        run_op("divzero_neg", 16'h8000, 16'h0000, Q_MIN, 1'b0, 1'b1);
        run_op("neg_half", 16'hE000, Q_ONE, 16'hE000, 1'b0, 1'b0);
        run_op("one_by_negone", Q_ONE, 16'hC000, 16'hC000, 1'b0, 1'b0);
        run_op("third", 16'h1000, 16'h3000, 16'h1555, 1'b0, 1'b0);
`ifdef DIV16_ROUND_EN
        run_op("tiny_pos", 16'h0001, 16'h6000, 16'h0001, 1'b0, 1'b0);
        run_op("tiny_neg", 16'hFFFF, 16'h6000, 16'hFFFF, 1'b0, 1'b0);
`else
        run_op("tiny_pos", 16'h0001, 16'h6000, 16'h0000, 1'b0, 1'b0);
        run_op("tiny_neg", 16'hFFFF, 16'h6000, 16'h0000, 1'b0, 1'b0);
`endif

        // Back-pressure: result must hold while a second request is ignored.
        out_ready = 1'b0;
        start_op("hold", 16'h2000, Q_ONE);
        wait_result("hold", 16'h2000, 1'b0, 1'b0);
        a        = Q_ONE;
        b        = Q_ONE;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold.out_valid", out_valid, 1);
            check("hold.q", q, 16'h2000);
            check("hold.in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release.out_valid", out_valid, 0);
        check("release.in_ready", in_ready, 1);
        check("release.q_held", q, 16'h2000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("second.accepted", in_ready, 0);
        wait_result("second", Q_ONE, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a calculation.
        start_op("abort", 16'h2000, 16'h6000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.out_valid", out_valid, 0);
        check("abort.in_ready", in_ready, 1);
        check("abort.q", q, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_reset", Q_ONE, Q_ONE, Q_ONE, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
